// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART transmit arbiter.
// Holds the data width and the arbiter FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ARB       = 3'd1;
  localparam state_t ST_LOAD      = 3'd2;
  localparam state_t ST_WAIT_BUSY = 3'd3;
  localparam state_t ST_WAIT_DONE = 3'd4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Ports: valid_i (requests), ptr_i (start index) -> gnt_o (one-hot),
//        idx_o (binary index of winner), any_o (some request valid).
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int j;

  // Scan ptr, ptr+1, ... with wrap; first valid wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && valid_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte sources.
// Ports: clk, rst (sync, active-high); req_valid/req_byte/req_last in,
//   req_ready out (per client); tx_byte/tx_en out, tx_ready in (to uart);
//   grant (one-hot owner), burst_cut and ack_err status pulses out.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MAX_BURST   = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_byte,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [UART_DATA_W-1:0]   tx_byte,
  output logic                     tx_en,
  input  logic                     tx_ready,
  output logic [N_REQ-1:0]         grant,
  output logic                     burst_cut,
  output logic                     ack_err
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t                 state_q;
  logic [N_REQ-1:0]       grant_q;
  logic [PW-1:0]          gidx_q;
  logic [PW-1:0]          ptr_q;
  logic [7:0]             burst_q;
  logic [TW-1:0]          tcnt_q;
  logic                   last_q;
  logic [UART_DATA_W-1:0] tx_byte_q;
  logic                   tx_en_q;
  logic [N_REQ-1:0]       req_ready_q;
  logic                   burst_cut_q;
  logic                   ack_err_q;

  logic [N_REQ-1:0]       pick_gnt;
  logic [PW-1:0]          pick_idx;
  logic                   pick_any;

  logic                   sel_valid;
  logic                   sel_last;
  logic [UART_DATA_W-1:0] sel_byte;
  logic [PW-1:0]          nxt_ptr;
  logic                   burst_full;
  logic                   tmo_hit;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign sel_valid  = req_valid[gidx_q];
  assign sel_last   = req_last[gidx_q];
  assign sel_byte   = req_byte[gidx_q*UART_DATA_W +: UART_DATA_W];
  assign nxt_ptr    = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign burst_full = (burst_q >= 8'(MAX_BURST));
  assign tmo_hit    = (tcnt_q >= TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      burst_q     <= '0;
      tcnt_q      <= '0;
      last_q      <= 1'b0;
      tx_byte_q   <= '0;
      tx_en_q     <= 1'b0;
      req_ready_q <= '0;
      burst_cut_q <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      tx_en_q     <= 1'b0;
      req_ready_q <= '0;
      burst_cut_q <= 1'b0;
      ack_err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|req_valid) state_q <= ST_ARB;
        end
        ST_ARB: begin
          if (pick_any) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (tx_ready && sel_valid) begin
            tx_byte_q   <= sel_byte;
            tx_en_q     <= 1'b1;
            req_ready_q <= grant_q;
            last_q      <= sel_last;
            tcnt_q      <= '0;
            if (burst_q != 8'hFF) burst_q <= burst_q + 8'd1;
            state_q     <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!tx_ready) begin
            tcnt_q  <= '0;
            state_q <= ST_WAIT_DONE;
          end else if (tmo_hit) begin
            // uart missed the strobe: retry with the held byte
            tx_en_q   <= 1'b1;
            ack_err_q <= 1'b1;
            tcnt_q    <= '0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) begin
            if (last_q || burst_full || !sel_valid) begin
              grant_q     <= '0;
              ptr_q       <= nxt_ptr;
              burst_q     <= '0;
              burst_cut_q <= !last_q && burst_full;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_byte   = tx_byte_q;
  assign tx_en     = tx_en_q;
  assign req_ready = req_ready_q;
  assign grant     = grant_q;
  assign burst_cut = burst_cut_q;
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter.
// Client queues feed the arbiter; a uart model goes busy 10 cycles per byte.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_byte = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_byte;
  logic             tx_en;
  logic             tx_ready;
  logic [N-1:0]     grant;
  logic             burst_cut;
  logic             ack_err;

  always #10 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .MAX_BURST   (16),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_byte  (req_byte),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_byte   (tx_byte),
    .tx_en     (tx_en),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .burst_cut (burst_cut),
    .ack_err   (ack_err)
  );

  // uart model
  int busy_cnt = 0;
  int ign_n    = 0;
  int ign_cnt  = 0;

  assign tx_ready = (busy_cnt == 0);

  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    else if (tx_en) begin
      if (ign_cnt < ign_n) ign_cnt <= ign_cnt + 1;
      else busy_cnt <= 10;
    end
  end

  // client queues and monitor
  logic [8:0] cbuf [N][32];
  int wr [N] = '{default: 0};
  int rd [N] = '{default: 0};
  int rise_cyc [N] = '{default: 0};
  int rdy_cnt [N] = '{default: 0};

  logic [7:0]   txb [64];
  logic [N-1:0] txg [64];
  int           txc [64];
  int n_tx    = 0;
  int ncyc    = 0;
  int viol    = 0;
  int n_ack   = 0;
  int ack_cyc = 0;
  int n_cut   = 0;
  int cut_at  = 0;

  always @(negedge clk) begin
    ncyc++;
    if (tx_en) begin
      if (n_tx < 64) begin
        txb[n_tx] = tx_byte;
        txg[n_tx] = grant;
        txc[n_tx] = ncyc;
      end
      n_tx++;
      if (!tx_ready) viol++;
    end
    if (ack_err) begin
      n_ack++;
      ack_cyc = ncyc;
    end
    if (burst_cut) begin
      n_cut++;
      cut_at = n_tx;
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        rdy_cnt[i]++;
        if (rd[i] < wr[i]) rd[i]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      logic v;
      logic [8:0] e;
      v = (rd[i] < wr[i]);
      e = v ? cbuf[i][rd[i] % 32] : 9'd0;
      if (v && !req_valid[i]) rise_cyc[i] = ncyc;
      req_valid[i]       = v;
      req_last[i]        = e[8];
      req_byte[8*i +: 8] = e[7:0];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [7:0] b, input logic l);
    cbuf[c][wr[c] % 32] = {l, b};
    wr[c]++;
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (rd[i] < wr[i]) e = 1'b0;
    return e;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (k > 2 && all_empty() && grant == '0 && tx_ready && !tx_en) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_push();
    @(posedge clk);
    #1;
  endtask

  int s;
  int a0;
  int r0;
  int c0;
  bit seen;

  initial begin
    // 1: reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_burst_cut", 32'(burst_cut), 0);
    chk("rst_ack_err", 32'(ack_err), 0);
    repeat (5) @(negedge clk);
    chk("idle_grant", 32'(grant), 0);
    chk("idle_no_tx", 32'(n_tx), 0);

    // 2: client 1, 3-byte packet
    start_push();
    s = n_tx;
    push(1, 8'h41, 1'b0);
    push(1, 8'h42, 1'b0);
    push(1, 8'h43, 1'b1);
    wait_done("t2", 200);
    chk("t2_count", 32'(n_tx - s), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_byte%0d", k), 32'(txb[s+k]), 32'h41 + k);
      chk($sformatf("t2_grant%0d", k), 32'(txg[s+k]), 32'b0010);
    end
    chk("t2_latency", 32'(txc[s] - rise_cyc[1]), 3);
    chk("t2_grant_rel", 32'(grant), 0);

    // pointer now 2: clients 1 and 3 tie -> 3 first
    start_push();
    s = n_tx;
    push(1, 8'h11, 1'b1);
    push(3, 8'h33, 1'b1);
    wait_done("t2b", 200);
    chk("t2b_count", 32'(n_tx - s), 2);
    chk("t2b_byte0", 32'(txb[s]), 32'h33);
    chk("t2b_grant0", 32'(txg[s]), 32'b1000);
    chk("t2b_byte1", 32'(txb[s+1]), 32'h11);
    chk("t2b_grant1", 32'(txg[s+1]), 32'b0010);

    // 3: pointer 0, clients 0 and 2 tie, no interleave
    do_reset();
    start_push();
    s = n_tx;
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b1);
    push(2, 8'hB0, 1'b0);
    push(2, 8'hB1, 1'b1);
    wait_done("t3", 300);
    chk("t3_count", 32'(n_tx - s), 4);
    chk("t3_b0", 32'(txb[s]), 32'hA0);
    chk("t3_b1", 32'(txb[s+1]), 32'hA1);
    chk("t3_b2", 32'(txb[s+2]), 32'hB0);
    chk("t3_b3", 32'(txb[s+3]), 32'hB1);
    chk("t3_g0", 32'(txg[s]), 32'b0001);
    chk("t3_g1", 32'(txg[s+1]), 32'b0001);
    chk("t3_g2", 32'(txg[s+2]), 32'b0100);
    chk("t3_g3", 32'(txg[s+3]), 32'b0100);

    // 4: pointer 3, client 3 streams 20 bytes, client 0 waiting
    start_push();
    s = n_tx;
    c0 = n_cut;
    for (int k = 0; k < 20; k++) push(3, 8'h60 + 8'(k), 1'b0);
    push(0, 8'hC0, 1'b1);
    wait_done("t4", 800);
    chk("t4_count", 32'(n_tx - s), 21);
    chk("t4_cuts", 32'(n_cut - c0), 1);
    chk("t4_cut_pos", 32'(cut_at - s), 16);
    for (int k = 0; k < 21; k++) begin
      logic [7:0]   eb;
      logic [N-1:0] eg;
      if (k < 16) begin
        eb = 8'h60 + 8'(k);
        eg = 4'b1000;
      end else if (k == 16) begin
        eb = 8'hC0;
        eg = 4'b0001;
      end else begin
        eb = 8'h60 + 8'(k - 1);
        eg = 4'b1000;
      end
      chk($sformatf("t4_byte%0d", k), 32'(txb[s+k]), 32'(eb));
      chk($sformatf("t4_grant%0d", k), 32'(txg[s+k]), 32'(eg));
    end

    // 5: uart misses the first strobe
    start_push();
    s = n_tx;
    a0 = n_ack;
    r0 = rdy_cnt[1];
    ign_n = ign_n + 1;
    push(1, 8'h5A, 1'b1);
    wait_done("t5", 200);
    chk("t5_count", 32'(n_tx - s), 2);
    chk("t5_byte0", 32'(txb[s]), 32'h5A);
    chk("t5_byte1", 32'(txb[s+1]), 32'h5A);
    chk("t5_acks", 32'(n_ack - a0), 1);
    chk("t5_ack_delay", 32'(ack_cyc - txc[s]), 8);
    chk("t5_retry_gap", 32'(txc[s+1] - txc[s]), 8);
    chk("t5_ready_pulses", 32'(rdy_cnt[1] - r0), 1);

    // 6: reset while the first byte is in flight
    start_push();
    s = n_tx;
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b0);
    push(2, 8'h73, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (n_tx > s) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_first_tx", 32'(seen), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_tx_en", 32'(tx_en), 0);
    chk("t6_rst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    wait_done("t6", 300);
    chk("t6_count", 32'(n_tx - s), 3);
    chk("t6_b0", 32'(txb[s]), 32'h71);
    chk("t6_b1", 32'(txb[s+1]), 32'h72);
    chk("t6_b2", 32'(txb[s+2]), 32'h73);
    chk("t6_g1", 32'(txg[s+1]), 32'b0100);
    chk("t6_wait_uart", 32'(txc[s+1] - txc[s] >= 12), 1);

    chk("tx_en_while_busy", 32'(viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
